// File: rtl/bus_sched.sv
// bus_sched: round-robin arbiter driving the shared bus mux source code, one settle cycle per grant.
// Define BUS_SCHED_TIMEOUT_EN to enable the hold watchdog (forced release after MAX_HOLD valid cycles).
module bus_sched #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] src_sel,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        read_en,
    output logic              bus_valid,
    output logic [NREQ-1:0]   err,
    output logic              busy
);
    // state  | meaning
    // IDLE   | no grant, bus mux deselected
    // SETTLE | grant and source code latched, bus settling, data not yet valid
    // GRANT  | data valid for the granted requester until it drops req
    typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_bad_param
        $error("bus_sched: parameter out of range");
    end

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [3:0]        read_en_q, read_en_d;
    logic [PW-1:0]     ptr_q, ptr_d, ptr_inc;
    logic [NREQ-1:0]   req_q;
    logic [NREQ-1:0]   err_q, err_d;
    logic [NREQ-1:0]   legal, elig, cand;
    logic              win_found, load, held, timeout;
    logic [PW-1:0]     win_idx;
    logic [PW:0]       inc_sum;

    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13: is_legal = 1'b1;
            default:                                          is_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        legal = '0;
        for (int i = 0; i < NREQ; i++) begin
            legal[i] = is_legal(src_sel[4*i +: 4]);
        end
    end

    assign held = |(req & gnt_q);

`ifdef BUS_SCHED_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0]   hold_q;
    logic [NREQ-1:0] mask_q;

    // hold_q is loaded leaving SETTLE, so it reaches zero on the last allowed valid cycle
    assign timeout = (state_q == GRANT) && held && (hold_q == '0);
    assign elig    = req & legal & ~mask_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            mask_q <= '0;
        end else begin
            if (state_q == SETTLE) begin
                hold_q <= HW'(MAX_HOLD - 1);
            end else if (state_q == GRANT && hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end
            mask_q <= (mask_q & req) | (timeout ? gnt_q : '0);
        end
    end
`else
    assign timeout = 1'b0;
    assign elig    = req & legal;
`endif

    // the releasing holder is never a candidate, even when forced off with req still high
    assign cand = elig & ~gnt_q;

    always_comb begin
        logic [PW:0] probe;
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = 0; k < NREQ; k++) begin
            probe = {1'b0, ptr_q} + (PW+1)'(k);
            if (probe >= (PW+1)'(NREQ)) begin
                probe = probe - (PW+1)'(NREQ);
            end
            if (!win_found && cand[probe[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = probe[PW-1:0];
            end
        end
    end

    assign inc_sum = {1'b0, win_idx} + (PW+1)'(1);
    assign ptr_inc = (inc_sum >= (PW+1)'(NREQ)) ? '0 : inc_sum[PW-1:0];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        read_en_d = read_en_q;
        ptr_d     = ptr_q;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    load = 1'b1;
                end
            end
            SETTLE: begin
                state_d = GRANT;
            end
            GRANT: begin
                if (!held || timeout) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        read_en_d = '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                read_en_d = '0;
            end
        endcase
        if (load) begin
            state_d   = SETTLE;
            gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            read_en_d = src_sel[{win_idx, 2'b00} +: 4];
            ptr_d     = ptr_inc;
        end
    end

    assign err_d = (req & ~req_q & ~legal) | (timeout ? gnt_q : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            read_en_q <= '0;
            ptr_q     <= '0;
            req_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            read_en_q <= read_en_d;
            ptr_q     <= ptr_d;
            req_q     <= req;
            err_q     <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign read_en   = read_en_q;
    assign bus_valid = (state_q == GRANT);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_bus_sched.sv
// Directed self-checking bench for bus_sched (NREQ=4, MAX_HOLD=8).
// Observed word is {gnt, read_en, bus_valid, busy, err}.
module tb_bus_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] src_sel;
    logic [3:0]  gnt;
    logic [3:0]  read_en;
    logic        bus_valid;
    logic [3:0]  err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [13:0] obs;
    logic [13:0] exp_v;

    assign obs = {gnt, read_en, bus_valid, busy, err};

    always #5 clk = ~clk;

    bus_sched #(.NREQ(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .src_sel   (src_sel),
        .gnt       (gnt),
        .read_en   (read_en),
        .bus_valid (bus_valid),
        .err       (err),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = 4'b1111;
        src_sel = {4'd8, 4'd9, 4'd7, 4'd5};
        tick();
        tick();
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_outputs got=%h want=%h", obs, exp_v); end
        rst_n = 1'b1;
        tick();
        exp_v = {4'b0001, 4'd5, 1'b0, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_first_grant got=%h want=%h", obs, exp_v); end
        tick();
        exp_v = {4'b0001, 4'd5, 1'b1, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_first_valid got=%h want=%h", obs, exp_v); end
        req = 4'b0000;
        tick();
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_release got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_single();
        src_sel = {4'd8, 4'd9, 4'd7, 4'd5};
        req     = 4'b0100;
        tick();
        exp_v = {4'b0100, 4'd9, 1'b0, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL single_grant got=%h want=%h", obs, exp_v); end
        tick();
        exp_v = {4'b0100, 4'd9, 1'b1, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL single_valid got=%h want=%h", obs, exp_v); end
        src_sel[11:8] = 4'd4;
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL single_code_latched got=%h want=%h", obs, exp_v); end
        req = 4'b0000;
        tick();
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL single_release got=%h want=%h", obs, exp_v); end
        src_sel = {4'd8, 4'd9, 4'd7, 4'd5};
    endtask

    task automatic test_back_to_back();
        int         order [4] = '{0, 1, 3, 0};
        logic [3:0] codes [4] = '{4'd5, 4'd7, 4'd9, 4'd12};
        int         w;
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n   = 1'b1;
        src_sel = {4'd12, 4'd9, 4'd7, 4'd5};
        req     = 4'b1011;
        tick();
        for (int n = 0; n < 4; n++) begin
            w = order[n];
            exp_v = {4'b0001 << w, codes[w], 1'b0, 1'b1, 4'b0000};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL rr_settle n=%0d got=%h want=%h", n, obs, exp_v); end
            tick();
            exp_v = {4'b0001 << w, codes[w], 1'b1, 1'b1, 4'b0000};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL rr_valid n=%0d got=%h want=%h", n, obs, exp_v); end
            tick();
            tick();
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL rr_hold n=%0d got=%h want=%h", n, obs, exp_v); end
            if (n == 3) req = 4'b0000;
            else        req[w] = 1'b0;
            tick();
            if (n < 3) req[w] = 1'b1;
        end
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rr_final_idle got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_illegal();
        src_sel = {4'd12, 4'd9, 4'd6, 4'd13};
        req     = 4'b0011;
        tick();
        exp_v = {4'b0001, 4'd13, 1'b0, 1'b1, 4'b0010};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL illegal_err_pulse got=%h want=%h", obs, exp_v); end
        tick();
        exp_v = {4'b0001, 4'd13, 1'b1, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL illegal_err_once got=%h want=%h", obs, exp_v); end
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL illegal_legal_served got=%h want=%h", obs, exp_v); end
        req = 4'b0010;
        tick();
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL illegal_not_granted got=%h want=%h", obs, exp_v); end
        tick();
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL illegal_still_idle got=%h want=%h", obs, exp_v); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_watchdog();
        src_sel = {4'd10, 4'd9, 4'd7, 4'd5};
        req     = 4'b1000;
        tick();
        exp_v = {4'b1000, 4'd10, 1'b0, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL hold_grant got=%h want=%h", obs, exp_v); end
`ifdef BUS_SCHED_TIMEOUT_EN
        for (int n = 0; n < 8; n++) begin
            tick();
            exp_v = {4'b1000, 4'd10, 1'b1, 1'b1, 4'b0000};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL wd_valid n=%0d got=%h want=%h", n, obs, exp_v); end
        end
        tick();
        exp_v = {4'b0000, 4'd0, 1'b0, 1'b0, 4'b1000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL wd_force_release got=%h want=%h", obs, exp_v); end
        tick();
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL wd_masked got=%h want=%h", obs, exp_v); end
        tick();
        tick();
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL wd_still_masked got=%h want=%h", obs, exp_v); end
        req = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        exp_v = {4'b1000, 4'd10, 1'b0, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL wd_regrant got=%h want=%h", obs, exp_v); end
        req = 4'b0000;
        tick();
        tick();
`else
        for (int n = 0; n < 12; n++) begin
            tick();
            exp_v = {4'b1000, 4'd10, 1'b1, 1'b1, 4'b0000};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL hold_valid n=%0d got=%h want=%h", n, obs, exp_v); end
        end
        req = 4'b0000;
        tick();
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL hold_release got=%h want=%h", obs, exp_v); end
`endif
    endtask

    task automatic test_reset_mid_grant();
        src_sel = {4'd8, 4'd9, 4'd7, 4'd5};
        req     = 4'b0100;
        tick();
        tick();
        exp_v = {4'b0100, 4'd9, 1'b1, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL midrst_in_grant got=%h want=%h", obs, exp_v); end
        rst_n = 1'b0;
        tick();
        exp_v = '0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL midrst_cleared got=%h want=%h", obs, exp_v); end
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        exp_v = {4'b0001, 4'd5, 1'b0, 1'b1, 4'b0000};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL midrst_ptr_zero got=%h want=%h", obs, exp_v); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0000;
        src_sel = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_watchdog();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_sched.md
# bus_sched

Sequencing controller for the shared 17-bit datapath bus. It arbitrates among `NREQ` requesters, each asking for one bus source code, and drives the bus multiplexer's 4-bit `read_en`. Each grant gets one settle cycle before data is declared valid. Illegal source codes are rejected, and an optional watchdog forces release of a grant that is held too long. The block sits between the control unit's micro-operation requesters (ALU, DM/IM address load, IR load, etc.) and the bus mux.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `MAX_HOLD`, 8, maximum cycles `bus_valid` may stay high for one grant (watchdog build only; ≥1).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `req`  in  NREQ  per-requester bus request, level-held until done.
- `src_sel`  in  4*NREQ  requester i source code in bits [4i+3:4i].
- `gnt`  out  NREQ  one-hot registered grant; all zero when idle.
- `read_en`  out  4  registered source code to bus mux; 4'd0 when no grant.
- `bus_valid`  out  1  bus data valid for granted requester.
- `err`  out  NREQ  one-cycle error pulse per requester.
- `busy`  out  1  high in SETTLE or GRANT.

## Operation
- Legal source codes: 4 (IR), 5 (AC), 7 (R1), 8 (R2), 9 (R3), 10 (R4), 12 (DM), 13 (IM). All other codes are illegal.
- Eligible requester: `req[i]`=1, legal `src_sel[i]`, and not masked.
- Illegal request:
  - Never granted.
  - `err[i]` pulses once on the rising edge of `req[i]` (registered `req` compare).
- States:
  - IDLE:
    - `gnt`=0, `read_en`=0, `bus_valid`=0.
    - If any requester is eligible: pick the winner round-robin, latch `gnt`/`read_en`, go to SETTLE.
  - SETTLE: exactly one cycle, `bus_valid`=0, then go to GRANT.
  - GRANT:
    - `bus_valid`=1 while `req[g]` stays high.
    - When `req[g]`=0: release. If another requester is eligible in the same cycle, hand over directly to SETTLE with the new `gnt`/`read_en`. Otherwise go to IDLE.
- Round-robin:
  - Pointer is set to g+1 (mod NREQ) on every grant.
  - Search starts at the pointer.
  - After reset the pointer is 0, so requester 0 has highest priority.
- `src_sel[g]` changes during SETTLE/GRANT are ignored; the code is latched at grant.
- Requests from non-granted requesters are held pending, never dropped.
- Reset values: `gnt`=0, `read_en`=0, `bus_valid`=0, `err`=0, `busy`=0, pointer 0, masks clear, state IDLE.
- Reset asserted mid-grant clears everything at that edge, with no release handshake.

## Timing
- `req[i]` high in IDLE at edge t:
  - `gnt[i]`, `read_en` valid after edge t.
  - `bus_valid` high after edge t+1.
  - Latency 2 cycles to valid data.
- `req[g]` low at edge t:
  - `bus_valid`, `gnt[g]` low after edge t.
  - Handover grant appears after edge t.
  - `bus_valid` for the new grant rises after edge t+1.
- Simultaneous requests: only one grant per cycle; others wait and are served in round-robin order.
- `err` is asserted for exactly one cycle per event.

## Configuration
- Macro: `BUS_SCHED_TIMEOUT_EN`.
- Defined:
  - A hold counter runs while in GRANT.
  - After `MAX_HOLD` cycles of `bus_valid`, the grant is force-released (same path as a normal release) and `err[g]` pulses once.
  - Requester g is masked until it drops `req[g]`.
- Undefined:
  - No counter, no forced release, no mask.
  - A grant lasts until `req[g]` falls.
  - `MAX_HOLD` is unused.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `req`=4'b1111 -> all outputs 0. After release, `gnt`=4'b0001 and `read_en`=`src_sel[3:0]`.
- Single request: `req[2]`=1, code 9 -> `gnt`=4'b0100 and `read_en`=9 next cycle; `bus_valid` the cycle after. Drop `req` -> everything returns to 0 one cycle later.
- Contention: `req`=4'b1011 held, each requester releasing 3 cycles after its `bus_valid` -> grant order 0,1,3,0; each handover has exactly one `bus_valid`=0 settle cycle.
- Illegal code: `req[1]`=1 with code 6 -> `err[1]` pulses once, `gnt[1]` never asserts, and `req[0]` with code 13 is still served.
- Watchdog (macro on, `MAX_HOLD`=8): `req[3]` held high -> after 8 `bus_valid` cycles, `gnt` clears and `err[3]` pulses. No regrant to requester 3 until `req[3]` toggles low then high.
- Reset during GRANT: `rst_n`=0 while `bus_valid`=1 -> `gnt`, `read_en`, `bus_valid` are 0 after that edge. The pointer restarts at 0.
